// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Sequences the transmitter's en/busy handshake, enforces an idle gap, flags a silent transmitter.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 8,
  parameter int GAP_CYCLES   = 2,
  parameter int ACK_TIMEOUT  = 16,
  localparam int IDW         = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            tx_en,
  output logic [PAYLOAD_BITS-1:0]         tx_data,
  input  logic                            tx_busy,
  output logic [IDW-1:0]                  grant_id,
  output logic                            active,
  output logic                            err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST   = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
  localparam state_t      AFTER_TX   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  state_t                  state, state_next;
  logic [IDW-1:0]          last;
  logic [15:0]             timer;
  logic [15:0]             gap_cnt;
  logic [PAYLOAD_BITS-1:0] req_bytes [NUM_REQ];
  logic                    win_found;
  logic [IDW-1:0]          win_idx;
  logic [IDW-1:0]          cand;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    end
  end

  // Search starts just after the last winner, so the requester just served ranks lowest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(last) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    req_ready   = '0;
    err_timeout = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          state_next         = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = S_WAIT_DONE;
        end else if (timer == TIMER_LAST) begin
          err_timeout = 1'b1;
          state_next  = AFTER_TX;
        end
      end
      S_WAIT_DONE: if (!tx_busy) state_next = AFTER_TX;
      S_GAP:       if (gap_cnt == GAP_LAST) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      tx_data  <= '0;
      grant_id <= '0;
      last     <= IDW'(NUM_REQ - 1);
      timer    <= '0;
      gap_cnt  <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && win_found) begin
        tx_data  <= req_bytes[win_idx];
        grant_id <= win_idx;
        last     <= win_idx;
      end
      // Counters run only while staying in their state, so each restarts at 0 on entry.
      timer   <= (state == S_WAIT_BUSY && state_next == S_WAIT_BUSY) ? timer + 16'd1 : 16'd0;
      gap_cnt <= (state == S_GAP && state_next == S_GAP) ? gap_cnt + 16'd1 : 16'd0;
    end
  end

  assign tx_en  = (state == S_ISSUE);
  assign active = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a transmitter model feeds an observed-frame queue that is
// scored against expected frames queued when requests are driven.
module tb_uart_tx_arbiter;

  localparam int BUSY_LEN = 3;

  logic        clk = 1'b0;
  logic        resetn;
  always #5 clk = ~clk;

  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_timeout;

  logic [3:0]  b_req_valid;
  logic [31:0] b_req_data;
  logic [3:0]  b_req_ready;
  logic        b_tx_en;
  logic [7:0]  b_tx_data;
  logic        b_tx_busy;
  logic [1:0]  b_grant_id;
  logic        b_active;
  logic        b_err_timeout;

  uart_tx_arbiter #(.NUM_REQ(4), .PAYLOAD_BITS(8), .GAP_CYCLES(2), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .err_timeout(err_timeout)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .PAYLOAD_BITS(8), .GAP_CYCLES(0), .ACK_TIMEOUT(16)) dut_nogap (
    .clk(clk), .resetn(resetn), .req_valid(b_req_valid), .req_data(b_req_data),
    .req_ready(b_req_ready), .tx_en(b_tx_en), .tx_data(b_tx_data), .tx_busy(b_tx_busy),
    .grant_id(b_grant_id), .active(b_active), .err_timeout(b_err_timeout)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] id;
  } frame_t;

  frame_t     sb_q[$];
  frame_t     obs_q[$];
  logic [7:0] b_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         frames_seen = 0;
  int         n_viol = 0;
  int         n_accept = 0;
  bit         no_busy = 1'b0;

  // Transmitter model: records each frame on tx_en and answers with a busy pulse.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_en) begin
        obs_q.push_back({tx_data, grant_id});
        frames_seen++;
        if (!no_busy) begin
          tx_busy = 1'b1;
          repeat (BUSY_LEN) @(negedge clk);
          tx_busy = 1'b0;
        end
      end
    end
  end

  // Looks at handshake inputs just before each rising edge.
  always @(negedge clk) begin
    #3;
    if ((active && |req_ready) || $countones(req_ready) > 1) n_viol++;
    if (|(req_valid & req_ready)) n_accept++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required the run to finish earlier");
    $fatal(1, "time limit");
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset;
    resetn = 1'b0;
    step;
    resetn = 1'b1;
    step;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (active && n < 100) begin
      step;
      n++;
    end
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle: active=%b after %0d clocks, required 0", tag, active, n);
    end
  endtask

  task automatic run_frames(input int cnt, input string tag);
    int target = frames_seen + cnt;
    int n = 0;
    while (frames_seen < target && n < 400) begin
      step;
      n++;
    end
    req_valid = '0;
    n_cmp++;
    if (frames_seen < target) begin
      n_err++;
      $display("FAIL %s_frames: saw %0d frames, required %0d", tag, frames_seen, target);
    end
    wait_idle(tag);
  endtask

  task automatic score_frames(input string tag);
    frame_t e, o;
    n_cmp++;
    if (obs_q.size() != sb_q.size()) begin
      n_err++;
      $display("FAIL %s_count: observed %0d frames, required %0d", tag, obs_q.size(), sb_q.size());
    end
    while (sb_q.size() > 0 && obs_q.size() > 0) begin
      e = sb_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s_frame: got data=%02h id=%0d, required data=%02h id=%0d",
                 tag, o.data, o.id, e.data, e.id);
      end
    end
    sb_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset;
    repeat (2) step;
    n_cmp++;
    if ({req_ready, tx_en, tx_data, grant_id, active, err_timeout} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%b en=%b data=%02h id=%0d active=%b err=%b, required all 0",
               req_ready, tx_en, tx_data, grant_id, active, err_timeout);
    end
    n_cmp++;
    if ({b_req_ready, b_tx_en, b_tx_data, b_grant_id, b_active, b_err_timeout} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs_nogap: ready=%b en=%b data=%02h, required all 0",
               b_req_ready, b_tx_en, b_tx_data);
    end
    resetn = 1'b1;
    step;
  endtask

  task automatic test_single;
    int n;
    req_data[7:0] = 8'hA5;
    req_valid     = 4'b0001;
    sb_q.push_back({8'hA5, 2'd0});
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL single_ready: req_ready=%b, required 0001", req_ready);
    end
    step;
    n_cmp++;
    if (tx_en !== 1'b1 || req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL single_issue: tx_en=%b req_ready=%b, required 1 and 0000", tx_en, req_ready);
    end
    req_valid = '0;
    n_cmp++;
    if (tx_data !== 8'hA5 || grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL single_data: tx_data=%02h grant_id=%0d, required a5 and 0", tx_data, grant_id);
    end
    n = 0;
    while (tx_busy !== 1'b0 && n < 50) begin
      step;
      n++;
    end
    n = 0;
    while (active && n < 20) begin
      step;
      n++;
    end
    n_cmp++;
    if (n != 3) begin
      n_err++;
      $display("FAIL single_active_fall: active fell %0d clocks after tx_busy, required 3", n);
    end
    score_frames("single");
  endtask

  task automatic test_round_robin;
    int acc0;
    apply_reset;
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    sb_q.push_back({8'h11, 2'd0});
    sb_q.push_back({8'h22, 2'd1});
    sb_q.push_back({8'h33, 2'd2});
    sb_q.push_back({8'h44, 2'd3});
    sb_q.push_back({8'h11, 2'd0});
    acc0 = n_accept;
    run_frames(5, "rr");
    n_cmp++;
    if (n_accept - acc0 != 5) begin
      n_err++;
      $display("FAIL rr_accepts: %0d accepts, required 5", n_accept - acc0);
    end
    score_frames("rr");
  endtask

  task automatic test_timeout;
    int n;
    int extra = 0;
    no_busy = 1'b1;
    req_data[23:16] = 8'h5A;
    req_valid       = 4'b0100;
    sb_q.push_back({8'h5A, 2'd2});
    n = 0;
    do begin step; n++; end while (!tx_en && n < 10);
    req_valid = '0;
    n = 0;
    do begin step; n++; end while (!err_timeout && n < 40);
    n_cmp++;
    if (n != 16) begin
      n_err++;
      $display("FAIL timeout_latency: err_timeout %0d clocks after tx_en, required 16", n);
    end
    repeat (20) begin
      step;
      if (err_timeout) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++;
      $display("FAIL timeout_once: %0d extra err_timeout pulses, required 0", extra);
    end
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_return: active=%b, required 0", active);
    end
    no_busy = 1'b0;
    req_data[15:8] = 8'h77;
    req_valid      = 4'b0010;
    sb_q.push_back({8'h77, 2'd1});
    run_frames(1, "after_timeout");
    score_frames("timeout");
  endtask

  task automatic test_rr_priority;
    int acc0;
    req_data[15:8]  = 8'hB1;
    req_data[31:24] = 8'hB3;
    req_valid       = 4'b1010;
    sb_q.push_back({8'hB3, 2'd3});
    sb_q.push_back({8'hB1, 2'd1});
    acc0 = n_accept;
    run_frames(2, "prio");
    n_cmp++;
    if (n_accept - acc0 != 2) begin
      n_err++;
      $display("FAIL prio_accepts: %0d accepts, required 2", n_accept - acc0);
    end
    score_frames("prio");
  endtask

  task automatic test_reset_mid_frame;
    int n;
    int en_cnt = 0;
    req_data[7:0] = 8'hC3;
    req_valid     = 4'b0001;
    sb_q.push_back({8'hC3, 2'd0});
    n = 0;
    do begin step; n++; end while (!tx_en && n < 10);
    req_valid = '0;
    step;
    step;
    n_cmp++;
    if (active !== 1'b1 || tx_busy !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_setup: active=%b tx_busy=%b, required 1 and 1", active, tx_busy);
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, tx_en, tx_data, grant_id, active, err_timeout} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: ready=%b en=%b data=%02h id=%0d active=%b err=%b, required all 0",
               req_ready, tx_en, tx_data, grant_id, active, err_timeout);
    end
    step;
    resetn = 1'b1;
    repeat (30) begin
      step;
      if (tx_en) en_cnt++;
    end
    n_cmp++;
    if (en_cnt != 0) begin
      n_err++;
      $display("FAIL midreset_no_tx_en: %0d tx_en pulses after release, required 0", en_cnt);
    end
    score_frames("midreset");
    req_data[23:16] = 8'hD2;
    req_valid       = 4'b0100;
    sb_q.push_back({8'hD2, 2'd2});
    run_frames(1, "after_reset");
    score_frames("after_reset");
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    logic [7:0] exp_b;
    logic [3:0] exp_ready;
    int n;
    bytes       = '{8'hE1, 8'hE2, 8'hE3};
    b_req_valid = 4'b0100;
    for (int f = 0; f < 3; f++) begin
      b_req_data[23:16] = bytes[f];
      b_q.push_back(bytes[f]);
      n = 0;
      do begin step; n++; end while (!b_tx_en && n < 10);
      exp_b = b_q.pop_front();
      n_cmp++;
      if (b_tx_en !== 1'b1 || b_tx_data !== exp_b || b_grant_id !== 2'd2) begin
        n_err++;
        $display("FAIL b2b_frame%0d: tx_en=%b data=%02h id=%0d, required 1 %02h 2",
                 f, b_tx_en, b_tx_data, b_grant_id, exp_b);
      end
      if (f == 2) b_req_valid = '0;
      b_tx_busy = 1'b1;
      repeat (BUSY_LEN) step;
      b_tx_busy = 1'b0;
      step;
      exp_ready = (f < 2) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (b_active !== 1'b0 || b_req_ready !== exp_ready) begin
        n_err++;
        $display("FAIL b2b_next%0d: active=%b req_ready=%b, required 0 and %b",
                 f, b_active, b_req_ready, exp_ready);
      end
    end
  endtask

  task automatic test_invariants;
    n_cmp++;
    if (n_viol != 0) begin
      n_err++;
      $display("FAIL ready_invariant: %0d cycles with req_ready outside IDLE or not one-hot, required 0",
               n_viol);
    end
  endtask

  initial begin
    resetn      = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    b_req_valid = '0;
    b_req_data  = '0;
    b_tx_busy   = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_timeout;
    test_rr_priority;
    test_reset_mid_frame;
    test_back_to_back;
    test_invariants;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
